parking_meter_multi: RTL

PARKING_METER_MULTI -- requirements
Module: parking_meter_multi

---
 rtl/parking_meter_multi.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/parking_meter_multi.sv
// Multi-bay parking meter: one 14-bit seconds counter per bay, a shared
// one-second tick, per-bay coin/preset commands, and a multiplexed 4-digit
// seven-segment display of the selected bay with solid/blink/flash modes.
module parking_meter_multi #(
  parameter int NUM_BAYS  = 2,
  parameter int TICK_DIV  = 100,
  parameter int FLASH_DIV = 50,
  parameter int SCAN_DIV  = 1,
  parameter int MAX_TIME  = 9999,
  parameter int WARN_TIME = 180,
  parameter int COIN0     = 60,
  parameter int COIN1     = 120,
  parameter int COIN2     = 180,
  parameter int COIN3     = 300,
  parameter int PRESET_A  = 16,
  parameter int PRESET_B  = 150,
  localparam int SEL_W    = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          add,
  input  logic                ld_a,
  input  logic                ld_b,
  input  logic [SEL_W-1:0]    bay_sel,
  input  logic [SEL_W-1:0]    disp_sel,
  output logic [NUM_BAYS-1:0] expired,
  output logic [NUM_BAYS-1:0] low,
  output logic [15:0]         bcd,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int TDIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FDIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int SDIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [14:0] MAX_W = 15'(MAX_TIME);

  // Coin add with tick decrement folded in, evaluated at 15 bits so the
  // sum can exceed the ceiling without wrapping before it is clamped.
  function automatic logic [13:0] coin_sat(input logic [13:0] c,
                                           input logic [14:0] coin,
                                           input logic        t);
    logic [14:0] sum;
    sum = {1'b0, c} + coin - {14'd0, t};
    return (sum > MAX_W) ? MAX_W[13:0] : sum[13:0];
  endfunction

  // Preset load, less one second when it lands on a tick (floored at 0).
  function automatic logic [13:0] preset_val(input logic [14:0] p,
                                             input logic        t);
    return (p > {14'd0, t}) ? 14'(p - {14'd0, t}) : 14'd0;
  endfunction

  function automatic logic [15:0] to_bcd(input logic [13:0] c);
    int v;
    v = int'(c);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [TDIV_W-1:0] tdiv_q, tdiv_d;
  logic [FDIV_W-1:0] fdiv_q, fdiv_d;
  logic [SDIV_W-1:0] sdiv_q, sdiv_d;
  logic              flash_q, flash_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [13:0]       cnt_q [NUM_BAYS];
  logic [13:0]       cnt_d [NUM_BAYS];
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              tick;
  logic              cmd_ok;
  logic              coin_hit;
  logic [14:0]       coin_val;
  logic              disp_ok;
  logic [13:0]       disp_cnt;
  logic              lit;
  logic [3:0]        digit;

  assign tick   = (tdiv_q == TDIV_W'(TICK_DIV - 1));
  assign cmd_ok = (int'(bay_sel) < NUM_BAYS);

  // Free-running dividers: one-second tick, flash phase, scan pointer.
  always_comb begin
    tdiv_d  = tick ? '0 : tdiv_q + 1'b1;
    fdiv_d  = fdiv_q + 1'b1;
    flash_d = flash_q;
    if (fdiv_q == FDIV_W'(FLASH_DIV - 1)) begin
      fdiv_d  = '0;
      flash_d = ~flash_q;
    end
    sdiv_d = sdiv_q + 1'b1;
    ptr_d  = ptr_q;
    if (sdiv_q == SDIV_W'(SCAN_DIV - 1)) begin
      sdiv_d = '0;
      ptr_d  = ptr_q + 2'd1;
    end
  end

  // Divider and scan state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdiv_q  <= '0;
      fdiv_q  <= '0;
      sdiv_q  <= '0;
      flash_q <= 1'b1;
      ptr_q   <= 2'd0;
    end else begin
      tdiv_q  <= tdiv_d;
      fdiv_q  <= fdiv_d;
      sdiv_q  <= sdiv_d;
      flash_q <= flash_d;
      ptr_q   <= ptr_d;
    end
  end

  // Lowest-numbered coin input wins when several are pulsed together.
  always_comb begin
    coin_hit = 1'b1;
    coin_val = 15'(COIN0);
    if (add[0])      coin_val = 15'(COIN0);
    else if (add[1]) coin_val = 15'(COIN1);
    else if (add[2]) coin_val = 15'(COIN2);
    else if (add[3]) coin_val = 15'(COIN3);
    else             coin_hit = 1'b0;
  end

  // Per-bay next count: tick decrement everywhere, then the single
  // highest-priority command overrides it on the selected bay.
  always_comb begin
    for (int i = 0; i < NUM_BAYS; i++) begin
      cnt_d[i] = (tick && cnt_q[i] != 14'd0) ? cnt_q[i] - 14'd1 : cnt_q[i];
      if (cmd_ok && int'(bay_sel) == i) begin
        if (ld_a)          cnt_d[i] = preset_val(15'(PRESET_A), tick);
        else if (ld_b)     cnt_d[i] = preset_val(15'(PRESET_B), tick);
        else if (coin_hit) cnt_d[i] = coin_sat(cnt_q[i], coin_val, tick);
      end
    end
  end

  // Bay count registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BAYS; i++) begin
      if (!rst_n) cnt_q[i] <= 14'd0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end

  // Status flags for every bay.
  always_comb begin
    for (int i = 0; i < NUM_BAYS; i++) begin
      expired[i] = (cnt_q[i] == 14'd0);
      low[i]     = (cnt_q[i] != 14'd0) && (int'(cnt_q[i]) < WARN_TIME);
    end
  end

  // Pick the displayed bay; an out-of-range selection shows nothing.
  always_comb begin
    disp_ok  = 1'b0;
    disp_cnt = 14'd0;
    for (int i = 0; i < NUM_BAYS; i++) begin
      if (int'(disp_sel) == i) begin
        disp_ok  = 1'b1;
        disp_cnt = cnt_q[i];
      end
    end
  end

  assign bcd = disp_ok ? to_bcd(disp_cnt) : 16'd0;

  // Display mode and digit for the current scan slot.
  always_comb begin
    if (!disp_ok)                          lit = 1'b0;
    else if (int'(disp_cnt) >= WARN_TIME)  lit = 1'b1;
    else if (disp_cnt != 14'd0)            lit = ~disp_cnt[0];
    else                                   lit = flash_q;
    case (ptr_q)
      2'd0:    digit = bcd[3:0];
      2'd1:    digit = bcd[7:4];
      2'd2:    digit = bcd[11:8];
      default: digit = bcd[15:12];
    endcase
    an_d  = 4'b1111;
    seg_d = seg_q;
    if (lit) begin
      an_d  = ~(4'b0001 << ptr_q);
      seg_d = seg_enc(digit);
    end
  end

  // Registered display drive; seg holds its last pattern while blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
